fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_defs.sv | 29 ++
 rtl/if_id_reg.sv | 40 ++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared fetch definitions: address window, NOP encoding, fetch state encoding, IF/ID payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_defs;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_LIMIT = 32'h0000_6FFC;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
  } ifid_t;

  // Outside [lo, hi] or not word aligned.
  function automatic logic pc_illegal(input logic [31:0] p,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
    return (p < lo) || (p > hi) || (p[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID payload register with bubble, load and hold controls.
// Latency: one cycle from inputs to id_* outputs.
// Backpressure: hold keeps contents; bubble overrides hold and load.
module if_id_reg
  import cpu_defs::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] pc8,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid
);

  ifid_t q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      id_valid <= 1'b0;
    end else if (bubble) begin
      q        <= '{instr: NOP, pc: 32'h0, pc8: 32'h0};
      id_valid <= 1'b0;
    end else if (load && !hold) begin
      q        <= '{instr: instr, pc: pc, pc8: pc8};
      id_valid <= 1'b1;
    end
  end

  assign id_instr = q.instr;
  assign id_pc    = q.pc;
  assign id_pc8   = q.pc8;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, redirect buffering under stall, illegal-PC fault trap.
// Latency: im_addr combinational from pc; IF/ID payload one cycle after fetch.
// Backpressure: stall holds PC and IF/ID; a redirect seen during stall is parked until stall drops.
module fetch_unit #(
  parameter logic [31:0] PC_RESET = cpu_defs::PC_RESET,
  parameter logic [31:0] PC_LIMIT = cpu_defs::PC_LIMIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic [11:0] im_addr,
  input  logic [31:0] im_instr,
  output logic [31:0] pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        fetch_fault,
  output logic [31:0] fetch_cnt
);
  import cpu_defs::*;

  fetch_state_t state;
  logic         pend_vld;
  logic [31:0]  pend_pc;
  logic         illegal;
  logic         run_ok;
  logic         issue;
  logic [31:0]  pc4;
  logic [31:0]  pc8;

  assign illegal = pc_illegal(pc, PC_RESET, PC_LIMIT);
  assign run_ok  = (state == RUN) && !illegal;
  assign issue   = run_ok && !stall && !flush;
  assign pc4     = pc + 32'd4;
  assign pc8     = pc + 32'd8;
  assign im_addr = pc[13:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= PC_RESET;
      pend_vld    <= 1'b0;
      pend_pc     <= 32'h0;
      fetch_fault <= 1'b0;
      fetch_cnt   <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
          pc    <= PC_RESET;
        end
        RUN: begin
          if (illegal) begin
            // PC stays on the offending address for post-mortem.
            state       <= FAULT;
            fetch_fault <= 1'b1;
            pend_vld    <= 1'b0;
          end else begin
            if (!stall) begin
              pend_vld <= 1'b0;
              if (pend_vld)         pc <= pend_pc;
              else if (redir_valid) pc <= redir_pc;
              else                  pc <= pc4;
            end else if (redir_valid) begin
              pend_vld <= 1'b1;
              pend_pc  <= redir_pc;
            end
            if (issue) fetch_cnt <= fetch_cnt + 32'd1;
          end
        end
        FAULT: begin
        end
        default: state <= FAULT;
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (run_ok),
    .hold    (stall),
    .bubble  (!run_ok || flush),
    .instr   (im_instr),
    .pc      (pc),
    .pc8     (pc8),
    .id_instr(id_instr),
    .id_pc   (id_pc),
    .id_pc8  (id_pc8),
    .id_valid(id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences, random run vs reference model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic [11:0] im_addr;
  logic [31:0] im_instr, pc, id_instr, id_pc, id_pc8, fetch_cnt;
  logic        id_valid, fetch_fault;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] imem(input logic [11:0] a);
    return {8'hA5, a, ~a};
  endfunction

  assign im_instr = imem(im_addr);

  always #5 clk = ~clk;

  fetch_unit #(.PC_RESET(32'h0000_3000), .PC_LIMIT(32'h0000_6FFC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .redir_valid(redir_valid), .redir_pc(redir_pc), .im_addr(im_addr),
    .im_instr(im_instr), .pc(pc), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc8(id_pc8), .id_valid(id_valid), .fetch_fault(fetch_fault),
    .fetch_cnt(fetch_cnt)
  );

  // ---------------- reference model ----------------
  logic        m_boot, m_faulted, m_vld;
  logic [31:0] m_pc, m_cnt, m_instr, m_idpc;
  logic [31:0] m_pend[$];

  function automatic logic m_illegal(input logic [31:0] p);
    return (p < 32'h0000_3000) || (p > 32'h0000_6FFC) || (p % 4 != 0);
  endfunction

  task automatic model_reset();
    m_boot = 1'b1; m_faulted = 1'b0; m_vld = 1'b0;
    m_pc = 32'h3000; m_cnt = 0; m_instr = 0; m_idpc = 0;
    m_pend.delete();
  endtask

  task automatic model_edge(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    if (m_boot) begin
      m_boot = 1'b0; m_vld = 1'b0; m_instr = 0;
    end else if (m_faulted) begin
      m_vld = 1'b0; m_instr = 0;
    end else if (m_illegal(m_pc)) begin
      m_faulted = 1'b1; m_vld = 1'b0; m_instr = 0;
    end else begin
      if (fl) begin
        m_vld = 1'b0; m_instr = 0;
      end else if (!st) begin
        m_vld = 1'b1; m_instr = imem(m_pc[13:2]); m_idpc = m_pc; m_cnt = m_cnt + 1;
      end
      if (!st) begin
        if (m_pend.size() > 0) m_pc = m_pend.pop_front();
        else if (rv)           m_pc = rpc;
        else                   m_pc = m_pc + 4;
      end else if (rv) begin
        m_pend.delete();
        m_pend.push_back(rpc);
      end
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".pc"},      pc, m_pc);
    chk({tag, ".im_addr"}, 32'(im_addr), 32'(m_pc[13:2]));
    chk({tag, ".vld"},     32'(id_valid), 32'(m_vld));
    chk({tag, ".instr"},   id_instr, m_instr);
    chk({tag, ".cnt"},     fetch_cnt, m_cnt);
    chk({tag, ".fault"},   32'(fetch_fault), 32'(m_faulted));
    if (m_vld) begin
      chk({tag, ".id_pc"},  id_pc, m_idpc);
      chk({tag, ".id_pc8"}, id_pc8, m_idpc + 32'd8);
    end
  endtask

  task automatic drive_edge(input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    stall = st; flush = fl; redir_valid = rv; redir_pc = rpc;
    @(posedge clk);
    model_edge(st, fl, rv, rpc);
    #1;
  endtask

  task automatic step(input string tag, input logic st, input logic fl, input logic rv, input logic [31:0] rpc);
    drive_edge(st, fl, rv, rpc);
    check_model(tag);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst.pc", pc, 32'h3000);
    chk("rst.id_instr", id_instr, 32'h0);
    chk("rst.id_pc", id_pc, 32'h0);
    chk("rst.id_pc8", id_pc8, 32'h0);
    chk("rst.id_valid", 32'(id_valid), 32'h0);
    chk("rst.fault", 32'(fetch_fault), 32'h0);
    chk("rst.cnt", fetch_cnt, 32'h0);
    stall = 1'b0; flush = 1'b0; redir_valid = 1'b0; redir_pc = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        st, fl, rv;
    logic [31:0] rpc;
    logic [31:0] e_pc, e_idpc;
    logic        e_vld;
    logic [31:0] e_cnt;
    logic        e_flt;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic st, input logic fl, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] e_pc, input logic [31:0] e_idpc, input logic e_vld,
                      input logic [31:0] e_cnt, input logic e_flt);
    vec_t v;
    v.st = st; v.fl = fl; v.rv = rv; v.rpc = rpc;
    v.e_pc = e_pc; v.e_idpc = e_idpc; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_flt = e_flt;
    tbl.push_back(v);
  endtask

  initial begin
    logic [31:0] rpc;
    logic        st, fl, rv;

    // stall flush rv rpc | pc id_pc vld cnt fault
    addv(0,0,0,32'h0,    32'h3000, 32'h0,    0, 0, 0); // BOOT edge
    addv(0,0,0,32'h0,    32'h3004, 32'h3000, 1, 1, 0);
    addv(0,0,0,32'h0,    32'h3008, 32'h3004, 1, 2, 0);
    addv(0,0,0,32'h0,    32'h300C, 32'h3008, 1, 3, 0);
    addv(0,0,0,32'h0,    32'h3010, 32'h300C, 1, 4, 0);
    addv(1,0,0,32'h0,    32'h3010, 32'h300C, 1, 4, 0); // stall x3 at 0x3010
    addv(1,0,0,32'h0,    32'h3010, 32'h300C, 1, 4, 0);
    addv(1,0,0,32'h0,    32'h3010, 32'h300C, 1, 4, 0);
    addv(0,0,0,32'h0,    32'h3014, 32'h3010, 1, 5, 0);
    addv(1,0,1,32'h3100, 32'h3014, 32'h3010, 1, 5, 0); // redirect parked
    addv(1,0,1,32'h3200, 32'h3014, 32'h3010, 1, 5, 0); // newer target wins
    addv(1,0,0,32'h0,    32'h3014, 32'h3010, 1, 5, 0);
    addv(0,0,0,32'h0,    32'h3200, 32'h3014, 1, 6, 0);
    addv(0,0,0,32'h0,    32'h3204, 32'h3200, 1, 7, 0);
    addv(1,1,0,32'h0,    32'h3204, 32'h0,    0, 7, 0); // flush beats stall
    addv(0,0,0,32'h0,    32'h3208, 32'h3204, 1, 8, 0);
    addv(0,1,1,32'h3300, 32'h3300, 32'h0,    0, 8, 0); // flush + redirect
    addv(0,0,0,32'h0,    32'h3304, 32'h3300, 1, 9, 0);
    addv(1,0,1,32'h3400, 32'h3304, 32'h3300, 1, 9, 0);
    addv(1,0,0,32'h0,    32'h3304, 32'h3300, 1, 9, 0);
    addv(0,0,0,32'h0,    32'h3400, 32'h3304, 1, 10, 0);
    addv(0,0,1,32'h3002, 32'h3002, 32'h3400, 1, 11, 0); // misaligned target
    addv(0,0,0,32'h0,    32'h3002, 32'h0,    0, 11, 1);
    addv(0,0,1,32'h3000, 32'h3002, 32'h0,    0, 11, 1); // frozen in FAULT

    async_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive_edge(tbl[i].st, tbl[i].fl, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("tbl%0d.pc", i), pc, tbl[i].e_pc);
      chk($sformatf("tbl%0d.vld", i), 32'(id_valid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d.cnt", i), fetch_cnt, tbl[i].e_cnt);
      chk($sformatf("tbl%0d.fault", i), 32'(fetch_fault), 32'(tbl[i].e_flt));
      chk($sformatf("tbl%0d.instr", i), id_instr,
          tbl[i].e_vld ? imem(tbl[i].e_idpc[13:2]) : 32'h0);
      if (tbl[i].e_vld) begin
        chk($sformatf("tbl%0d.id_pc", i), id_pc, tbl[i].e_idpc);
        chk($sformatf("tbl%0d.id_pc8", i), id_pc8, tbl[i].e_idpc + 32'd8);
      end
    end

    // Last legal word, then sequential fall-through to 0x7000 traps.
    async_reset();
    step("top", 0,0,0,32'h0);
    step("top", 0,0,0,32'h0);
    step("top", 0,0,1,32'h6FFC);
    step("top", 0,0,0,32'h0);
    chk("top.at_limit_vld", 32'(id_valid), 32'h1);
    step("top", 0,0,0,32'h0);
    chk("top.fault", 32'(fetch_fault), 32'h1);
    step("top", 0,0,1,32'h3000);
    step("top", 1,0,0,32'h0);
    chk("top.pc_frozen", pc, 32'h7000);
    chk("top.bubble", 32'(id_valid), 32'h0);

    // Just below the window.
    async_reset();
    step("low", 0,0,0,32'h0);
    step("low", 0,0,1,32'h2FFC);
    step("low", 0,0,0,32'h0);
    chk("low.fault", 32'(fetch_fault), 32'h1);
    chk("low.pc_frozen", pc, 32'h2FFC);

    // Reset while a redirect is parked: target must be lost.
    async_reset();
    step("pend", 0,0,0,32'h0);
    step("pend", 0,0,0,32'h0);
    step("pend", 1,0,1,32'h3500);
    step("pend", 1,0,0,32'h0);
    async_reset();
    step("pend", 0,0,0,32'h0);
    step("pend", 0,0,0,32'h0);
    chk("pend.lost", pc, 32'h3004);

    // Randomized run against the model.
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((m_faulted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        st = ($urandom_range(0, 3) == 0);
        fl = ($urandom_range(0, 6) == 0);
        rv = ($urandom_range(0, 6) == 0);
        if ($urandom_range(0, 19) != 0) rpc = 32'h3000 + (32'($urandom_range(0, 4095)) << 2);
        else begin
          case ($urandom_range(0, 3))
            0:       rpc = 32'h2FFC;
            1:       rpc = 32'h7000;
            2:       rpc = 32'h3000 + (32'($urandom_range(0, 4095)) << 2) + 32'($urandom_range(1, 3));
            default: rpc = $urandom;
          endcase
        end
        step("rnd", st, fl, rv, rpc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
